// File: rtl/echo_delay_ctrl.sv
// Echo/feedback delay controller: drives an external dual-port delay memory.
// Each accepted sample x is combined with the delayed, gain-scaled memory
// contents, saturated, written back into the delay line and presented on the
// output stream.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_CLEAR | zero the delay memory, one address per cycle, after reset
// ST_IDLE  | ready for a new input sample
// ST_READ  | issue the delay-line read at wr_ptr - delay
// ST_CALC  | read data present; compute and register saturated y
// ST_WRITE | write y back at wr_ptr, advance wr_ptr
// ST_OUT   | present y downstream until accepted
module echo_delay_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 512,
    parameter int GAIN_WIDTH = 8,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                  pi_clk,
    input  logic                  pi_areset_n,
    input  logic [DATA_WIDTH-1:0] pi_in_data,
    input  logic                  pi_in_valid,
    output logic                  po_in_ready,
    input  logic [ADDR_W-1:0]     pi_delay,
    input  logic [GAIN_WIDTH-1:0] pi_gain,
    output logic [DATA_WIDTH-1:0] po_out_data,
    output logic                  po_out_valid,
    input  logic                  pi_out_ready,
    output logic                  po_mem_w_en,
    output logic [ADDR_W-1:0]     po_mem_w_addr,
    output logic [DATA_WIDTH-1:0] po_mem_data,
    output logic                  po_mem_r_en,
    output logic [ADDR_W-1:0]     po_mem_r_addr,
    input  logic [DATA_WIDTH-1:0] pi_mem_data
);

    localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WRITE,
        ST_OUT
    } state_t;

    state_t state_q, state_nxt;

    logic [ADDR_W-1:0]     clr_cnt_q;
    logic [ADDR_W-1:0]     wr_ptr_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [ADDR_W-1:0]     delay_q;
    logic [GAIN_WIDTH-1:0] gain_q;
    logic [DATA_WIDTH-1:0] y_q;

    logic [ADDR_W:0]          rd_sum;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [PROD_W-1:0] mem_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_sh;
    logic [DATA_WIDTH:0]      echo_ext;
    logic [DATA_WIDTH:0]      x_ext;
    logic [DATA_WIDTH:0]      sum;
    logic [DATA_WIDTH-1:0]    y_sat;

    // State register; reset always restarts the memory clear.
    always_ff @(posedge pi_clk or negedge pi_areset_n) begin
        if (!pi_areset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; every working state lasts one cycle except IDLE/OUT.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == LAST_ADDR) state_nxt = ST_IDLE;
            ST_IDLE:  if (pi_in_valid) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_OUT;
            ST_OUT:   if (pi_out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Datapath registers: clear counter, input capture, result and write pointer.
    always_ff @(posedge pi_clk or negedge pi_areset_n) begin
        if (!pi_areset_n) begin
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            x_q       <= '0;
            delay_q   <= '0;
            gain_q    <= '0;
            y_q       <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) clr_cnt_q <= '0;
                    else                        clr_cnt_q <= clr_cnt_q + 1'b1;
                end
                ST_IDLE: begin
                    if (pi_in_valid) begin
                        x_q     <= pi_in_data;
                        delay_q <= pi_delay;
                        gain_q  <= pi_gain;
                    end
                end
                ST_CALC: y_q <= y_sat;
                ST_WRITE: begin
                    if (wr_ptr_q == LAST_ADDR) wr_ptr_q <= '0;
                    else                       wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Delay-line read address, modulo MEM_DEPTH; a delay of 0 means a full lap.
    always_comb begin
        rd_sum = {1'b0, wr_ptr_q} + DEPTH_EXT - {1'b0, delay_q};
        if (delay_q == '0) begin
            rd_addr = wr_ptr_q;
        end else if (rd_sum >= DEPTH_EXT) begin
            rd_addr = ADDR_W'(rd_sum - DEPTH_EXT);
        end else begin
            rd_addr = ADDR_W'(rd_sum);
        end
    end

    // Feedback term: signed sample times unsigned gain, floor-scaled by 2^-GAIN_WIDTH.
    always_comb begin
        mem_ext  = {{(GAIN_WIDTH + 1){pi_mem_data[DATA_WIDTH-1]}}, pi_mem_data};
        gain_ext = {{(DATA_WIDTH + 1){1'b0}}, gain_q};
        prod     = mem_ext * gain_ext;
        prod_sh  = prod >>> GAIN_WIDTH;
        echo_ext = prod_sh[DATA_WIDTH:0];
        x_ext    = {x_q[DATA_WIDTH-1], x_q};
        sum      = x_ext + echo_ext;
        // Overflow shows as disagreement between the two top bits of the wide sum.
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            y_sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH - 1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else begin
            y_sat = sum[DATA_WIDTH-1:0];
        end
    end

    // Outputs are decodes of the state register and held datapath registers.
    // The write enable is masked by reset so CLEAR does not write while held.
    assign po_in_ready   = (state_q == ST_IDLE);
    assign po_out_valid  = (state_q == ST_OUT);
    assign po_out_data   = y_q;
    assign po_mem_r_en   = (state_q == ST_READ);
    assign po_mem_r_addr = rd_addr;
    assign po_mem_w_en   = pi_areset_n & ((state_q == ST_CLEAR) | (state_q == ST_WRITE));
    assign po_mem_w_addr = (state_q == ST_CLEAR) ? clr_cnt_q : wr_ptr_q;
    assign po_mem_data   = (state_q == ST_CLEAR) ? '0 : y_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: a small dual-port memory model, a table of
// known vectors, hand-written corner sequences and a randomized run checked
// against an arithmetic model of the echo rule.
module tb_echo_delay_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 512;
    localparam int GW    = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          pi_clk;
    logic          pi_areset_n;
    logic [DW-1:0] pi_in_data;
    logic          pi_in_valid;
    logic          po_in_ready;
    logic [AW-1:0] pi_delay;
    logic [GW-1:0] pi_gain;
    logic [DW-1:0] po_out_data;
    logic          po_out_valid;
    logic          pi_out_ready;
    logic          po_mem_w_en;
    logic [AW-1:0] po_mem_w_addr;
    logic [DW-1:0] po_mem_data;
    logic          po_mem_r_en;
    logic [AW-1:0] po_mem_r_addr;
    logic [DW-1:0] pi_mem_data;

    echo_delay_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .GAIN_WIDTH(GW)) dut (
        .pi_clk        (pi_clk),
        .pi_areset_n   (pi_areset_n),
        .pi_in_data    (pi_in_data),
        .pi_in_valid   (pi_in_valid),
        .po_in_ready   (po_in_ready),
        .pi_delay      (pi_delay),
        .pi_gain       (pi_gain),
        .po_out_data   (po_out_data),
        .po_out_valid  (po_out_valid),
        .pi_out_ready  (pi_out_ready),
        .po_mem_w_en   (po_mem_w_en),
        .po_mem_w_addr (po_mem_w_addr),
        .po_mem_data   (po_mem_data),
        .po_mem_r_en   (po_mem_r_en),
        .po_mem_r_addr (po_mem_r_addr),
        .pi_mem_data   (pi_mem_data)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    // External delay memory: synchronous write, read data valid one cycle later.
    logic [DW-1:0] mem_q [DEPTH];
    always @(posedge pi_clk) begin
        if (po_mem_w_en) mem_q[po_mem_w_addr] <= po_mem_data;
        if (po_mem_r_en) pi_mem_data <= mem_q[po_mem_r_addr];
    end

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    // Read and write enables must never coincide.
    always @(negedge pi_clk) begin
        if (po_mem_r_en && po_mem_w_en) overlap++;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: delay line as a plain array of past outputs.
    int mdl_mem [DEPTH];
    int mdl_wp;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 0;
        mdl_wp = 0;
    endtask

    task automatic model_step(input int x, input int d, input int g,
                              output int y, output int ra, output int wa);
        int dd;
        longint e;
        longint s;
        dd = (d == 0) ? DEPTH : d;
        ra = (mdl_wp - dd + DEPTH) % DEPTH;
        e  = longint'(mdl_mem[ra]) * longint'(g);
        s  = longint'(x) + (e >>> GW);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        y  = int'(s);
        mdl_mem[mdl_wp] = y;
        wa = mdl_wp;
        mdl_wp = (mdl_wp + 1) % DEPTH;
    endtask

    // Hold reset, check cleared outputs, release and follow the full clear.
    task automatic do_reset();
        int cnt;
        int bad;
        pi_areset_n  = 1'b0;
        pi_in_valid  = 1'b0;
        pi_out_ready = 1'b0;
        repeat (2) @(negedge pi_clk);
        check("rst_in_ready",  po_in_ready, 0);
        check("rst_out_valid", po_out_valid, 0);
        check("rst_w_en",      po_mem_w_en, 0);
        check("rst_r_en",      po_mem_r_en, 0);
        check("rst_out_data",  po_out_data, 0);
        check("rst_mem_data",  po_mem_data, 0);
        check("rst_w_addr",    po_mem_w_addr, 0);
        check("rst_r_addr",    po_mem_r_addr, 0);
        pi_areset_n = 1'b1;
        #1;
        cnt = 0;
        bad = 0;
        for (int c = 0; c < DEPTH + 20; c++) begin
            if (po_in_ready) break;
            if (po_mem_w_en) begin
                if (int'(po_mem_w_addr) != cnt || po_mem_data != '0) bad++;
                cnt++;
            end
            if (po_mem_r_en) bad++;
            @(negedge pi_clk);
        end
        check("clear_writes", cnt, DEPTH);
        check("clear_content", bad, 0);
        check("ready_after_clear", po_in_ready, 1);
        model_reset();
    endtask

    // One sample through the block: handshake, latency, memory traffic,
    // optional output stall, then compare against the model.
    task automatic send_sample(input int x, input int d, input int g,
                               input int stall, output int y);
        int exp_y, exp_ra, exp_wa;
        int n, lat, ra, wa, rcnt, wcnt, bad;
        bit seen;
        logic [DW-1:0] held;
        model_step(x, d, g, exp_y, exp_ra, exp_wa);
        @(negedge pi_clk);
        n = 0;
        while (!po_in_ready && n < 50) begin
            @(negedge pi_clk);
            n++;
        end
        check("in_ready_wait", po_in_ready, 1);
        pi_in_data  = DW'(x);
        pi_delay    = AW'(d);
        pi_gain     = GW'(g);
        pi_in_valid = 1'b1;
        @(posedge pi_clk);
        #1;
        pi_in_valid = 1'b0;
        pi_in_data  = DW'($urandom);
        pi_delay    = AW'($urandom);
        pi_gain     = GW'($urandom);
        lat = 0; ra = -1; wa = -1; rcnt = 0; wcnt = 0; bad = 0; seen = 0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge pi_clk);
            lat++;
            if (po_mem_r_en) begin ra = int'(po_mem_r_addr); rcnt++; end
            if (po_mem_w_en) begin wa = int'(po_mem_w_addr); wcnt++; end
            if (po_out_valid) seen = 1;
            else if (po_in_ready) bad++;
        end
        check("latency", lat, 4);
        check("rd_addr", ra, exp_ra);
        check("wr_addr", wa, exp_wa);
        check("mem_access_cnt", rcnt * 10 + wcnt, 11);
        held = po_out_data;
        for (int c = 0; c < stall; c++) begin
            @(negedge pi_clk);
            if (po_out_data != held || !po_out_valid || po_in_ready
                || po_mem_r_en || po_mem_w_en) bad++;
        end
        check("busy_and_hold", bad, 0);
        y = int'($signed(po_out_data));
        check("y_model", y, exp_y);
        pi_out_ready = 1'b1;
        @(posedge pi_clk);
        #1;
        pi_out_ready = 1'b0;
    endtask

    typedef struct {
        bit rst;
        int x;
        int d;
        int g;
        int exp_y;
    } vec_t;

    vec_t vecs[$];
    int   y;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pi_areset_n  = 1'b0;
        pi_in_data   = '0;
        pi_in_valid  = 1'b0;
        pi_delay     = '0;
        pi_gain      = '0;
        pi_out_ready = 1'b0;
        model_reset();

        // Bypass, decaying impulse echo, positive and negative saturation.
        vecs.push_back('{rst:1, x:100,    d:5, g:0,   exp_y:100});
        vecs.push_back('{rst:0, x:-200,   d:7, g:0,   exp_y:-200});
        vecs.push_back('{rst:0, x:32767,  d:1, g:0,   exp_y:32767});
        vecs.push_back('{rst:1, x:1000,   d:3, g:128, exp_y:1000});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:500});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:250});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:0});
        vecs.push_back('{rst:0, x:0,      d:3, g:128, exp_y:125});
        vecs.push_back('{rst:1, x:30000,  d:1, g:255, exp_y:30000});
        vecs.push_back('{rst:0, x:30000,  d:1, g:255, exp_y:32767});
        vecs.push_back('{rst:0, x:30000,  d:1, g:255, exp_y:32767});
        vecs.push_back('{rst:1, x:-30000, d:1, g:255, exp_y:-30000});
        vecs.push_back('{rst:0, x:-30000, d:1, g:255, exp_y:-32768});
        vecs.push_back('{rst:0, x:-30000, d:1, g:255, exp_y:-32768});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            send_sample(vecs[i].x, vecs[i].d, vecs[i].g, 0, y);
            check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
        end

        // Full-lap delay: write pointer wraps and sample k returns at k+512.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            send_sample(int'($urandom_range(0, 16000)) - 8000, 0, 200, 0, y);
        end

        // Downstream stall of 10 cycles in OUT.
        send_sample(-1234, 4, 77, 10, y);

        // Reset asserted while in CALC: outputs clear at once, clear reruns.
        send_sample(1234, 2, 0, 0, y);
        @(negedge pi_clk);
        for (int c = 0; c < 20 && !po_in_ready; c++) @(negedge pi_clk);
        pi_in_data  = DW'(555);
        pi_delay    = AW'(1);
        pi_gain     = GW'(0);
        pi_in_valid = 1'b1;
        @(posedge pi_clk);
        #1;
        pi_in_valid = 1'b0;
        @(posedge pi_clk);
        #2;
        pi_areset_n = 1'b0;
        #1;
        check("calc_rst_out_data",  po_out_data, 0);
        check("calc_rst_mem_data",  po_mem_data, 0);
        check("calc_rst_out_valid", po_out_valid, 0);
        check("calc_rst_w_en",      po_mem_w_en, 0);
        check("calc_rst_r_en",      po_mem_r_en, 0);
        do_reset();
        send_sample(42, 1, 255, 0, y);
        check("post_rst_y", y, 42);

        // Randomized traffic with mid-sample input changes and short stalls.
        for (int k = 0; k < 300; k++) begin
            int x, d, g;
            x = int'($urandom_range(0, 65535)) - 32768;
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7))
                                            : int'($urandom_range(0, DEPTH - 1));
            g = int'($urandom_range(0, 255));
            send_sample(x, d, g, int'($urandom_range(0, 2)), y);
        end

        check("rw_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
